// File: rtl/cpu_defs.sv
// Shared CPU definitions: datapath width, reset constants and fetch FSM encoding.
package cpu_defs;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = '0;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StDrop = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one valid/ready read per fetch request, IR latch, flush handling.
// Optional misaligned-PC trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import cpu_defs::*;
#(
  parameter int unsigned     XLEN     = cpu_defs::XLEN,
  parameter logic [XLEN-1:0] RESET_IR = XLEN'(cpu_defs::NOP_INSN)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            fetch_req,
  input  logic            flush,
  input  logic [XLEN-1:0] current_pc,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic [XLEN-1:0] ir,
  output logic [XLEN-1:0] ir_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_done,
  output logic            pc_advance,
  output logic            busy,
  output logic            fetch_fault
);

  localparam logic [XLEN-1:0] AlignMask = {{(XLEN-2){1'b1}}, 2'b00};

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            flush_q, flush_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] ir_pc_q, ir_pc_d;
  logic            done_q, done_d;
  logic            adv_q, adv_d;
  logic            fault_q, fault_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      flush_q <= 1'b0;
      ir_q    <= RESET_IR;
      ir_pc_q <= '0;
      done_q  <= 1'b0;
      adv_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      flush_q <= flush_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      done_q  <= done_d;
      adv_q   <= adv_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    flush_d = flush_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    done_d  = 1'b0;
    adv_d   = 1'b0;
    fault_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fetch_req) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (current_pc[1:0] != 2'b00) begin
            // Trap instead of fetching; keep the raw PC for mtval.
            done_d  = 1'b1;
            fault_d = 1'b1;
            ir_pc_d = current_pc;
          end else begin
            addr_d  = current_pc & AlignMask;
            flush_d = 1'b0;
            state_d = StReq;
          end
`else
          addr_d  = current_pc & AlignMask;
          flush_d = 1'b0;
          state_d = StReq;
`endif
        end
      end

      StReq: begin
        if (mem_req_ready) begin
          state_d = (flush || flush_q) ? StDrop : StWait;
          flush_d = 1'b0;
        end else if (flush) begin
          // Request cannot be withdrawn, so remember the flush until it is accepted.
          flush_d = 1'b1;
        end
      end

      StWait: begin
        if (mem_rsp_valid) begin
          state_d = StIdle;
          if (!(flush || flush_q)) begin
            ir_d    = mem_rsp_data;
            ir_pc_d = addr_q;
            done_d  = 1'b1;
            adv_d   = 1'b1;
          end
        end else if (flush) begin
          state_d = StDrop;
        end
      end

      StDrop: begin
        if (mem_rsp_valid) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign mem_req_valid = (state_q == StReq);
  assign mem_req_addr  = addr_q;
  assign busy          = (state_q != StIdle);
  assign ir            = ir_q;
  assign ir_pc         = ir_pc_q;
  assign pc_plus4      = ir_pc_q + XLEN'(4);
  assign fetch_done    = done_q;
  assign pc_advance    = adv_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault   = fault_q;
`else
  assign fetch_fault   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized fetches against
// a transaction-level model (a fetch is discarded iff flush is seen from first REQ cycle to rsp).
module tb_fetch_unit;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic        fetch_req;
  logic        flush;
  logic [31:0] current_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic [31:0] pc_plus4;
  logic        fetch_done;
  logic        pc_advance;
  logic        busy;
  logic        fetch_fault;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ir_exp;
  logic [31:0] irpc_exp;

  fetch_unit dut (
    .clock        (clock),
    .reset        (reset),
    .fetch_req    (fetch_req),
    .flush        (flush),
    .current_pc   (current_pc),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr (mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .ir           (ir),
    .ir_pc        (ir_pc),
    .pc_plus4     (pc_plus4),
    .fetch_done   (fetch_done),
    .pc_advance   (pc_advance),
    .busy         (busy),
    .fetch_fault  (fetch_fault)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One fetch; flush_at indexes cycles from the first REQ cycle (-1 = fetch_req cycle).
  task automatic run_fetch(input string tag, input logic [31:0] pc, input logic [31:0] data,
                           input int rdy_dly, input int rsp_dly, input int flush_at);
    logic [31:0] addr_exp;
    int          last;
    int          idx;
    bit          discard;
    addr_exp = pc & 32'hFFFF_FFFC;
    last     = rdy_dly + 1 + rsp_dly;
    discard  = (flush_at >= 0) && (flush_at <= last);

    @(negedge clock);
    check_eq({tag, "/idle_done"}, 32'(fetch_done), 32'd0);
    check_eq({tag, "/idle_busy"}, 32'(busy), 32'd0);
    fetch_req  = 1'b1;
    current_pc = pc;
    flush      = (flush_at == -1);
    idx        = 0;

    for (int k = 0; k <= rdy_dly; k++) begin
      @(negedge clock);
      check_eq({tag, "/req_valid"}, 32'(mem_req_valid), 32'd1);
      check_eq({tag, "/req_addr"}, mem_req_addr, addr_exp);
      fetch_req     = 1'($urandom_range(0, 1));
      current_pc    = $urandom;
      mem_req_ready = (k == rdy_dly);
      flush         = (idx == flush_at);
      idx++;
    end

    for (int j = 0; j <= rsp_dly; j++) begin
      @(negedge clock);
      check_eq({tag, "/wait_valid"}, 32'(mem_req_valid), 32'd0);
      check_eq({tag, "/wait_busy"}, 32'(busy), 32'd1);
      mem_req_ready = 1'($urandom_range(0, 1));
      mem_rsp_valid = (j == rsp_dly);
      mem_rsp_data  = (j == rsp_dly) ? data : $urandom;
      flush         = (idx == flush_at);
      idx++;
    end

    @(negedge clock);
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    fetch_req     = 1'b0;
    flush         = (idx == flush_at);
    if (!discard) begin
      ir_exp   = data;
      irpc_exp = addr_exp;
    end
    check_eq({tag, "/done"}, 32'(fetch_done), 32'(!discard));
    check_eq({tag, "/advance"}, 32'(pc_advance), 32'(!discard));
    check_eq({tag, "/fault"}, 32'(fetch_fault), 32'd0);
    check_eq({tag, "/busy_end"}, 32'(busy), 32'd0);
    check_eq({tag, "/ir"}, ir, ir_exp);
    check_eq({tag, "/ir_pc"}, ir_pc, irpc_exp);
    check_eq({tag, "/plus4"}, pc_plus4, irpc_exp + 32'd4);
  endtask

  initial begin
    int          rdy;
    int          rsp;
    int          fl;
    logic [31:0] pc;

    reset         = 1'b1;
    fetch_req     = 1'b0;
    flush         = 1'b0;
    current_pc    = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    ir_exp        = Nop;
    irpc_exp      = '0;

    @(negedge clock);
    check_eq("rst_ir", ir, Nop);
    check_eq("rst_ir_pc", ir_pc, 32'd0);
    check_eq("rst_plus4", pc_plus4, 32'd4);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(mem_req_valid), 32'd0);
    check_eq("rst_done", 32'(fetch_done), 32'd0);
    check_eq("rst_fault", 32'(fetch_fault), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Minimum latency, then ready held low, then flush mid-wait.
    run_fetch("t1", 32'h0000_0100, 32'h0050_0093, 0, 0, -2);
    check_eq("t1_plus4", pc_plus4, 32'h0000_0104);
    run_fetch("t2", 32'h0000_0100, 32'h1234_5678, 3, 0, -2);
    run_fetch("t3", 32'h0000_0180, 32'hDEAD_BEEF, 0, 2, 1);
    run_fetch("t3b", 32'h0000_0200, 32'h0010_0113, 0, 0, -2);
    run_fetch("t4", 32'hFFFF_FFFC, 32'h0000_006F, 1, 1, -2);
    check_eq("t4_plus4", pc_plus4, 32'h0000_0000);
    run_fetch("tflr", 32'h0000_0400, 32'hAAAA_5555, 2, 1, 1);
    run_fetch("tflx", 32'h0000_0404, 32'h5555_AAAA, 0, 1, 2);

    // Reset while a read is outstanding; the late response must be ignored.
    @(negedge clock);
    fetch_req  = 1'b1;
    current_pc = 32'h0000_0300;
    @(negedge clock);
    fetch_req     = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    check_eq("t5_busy_wait", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1 check_eq("t5_busy_rst", 32'(busy), 32'd0);
    #1 reset = 1'b0;
    ir_exp   = Nop;
    irpc_exp = '0;
    @(negedge clock);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hBAD0_BAD0;
    @(negedge clock);
    mem_rsp_valid = 1'b0;
    check_eq("t5_done", 32'(fetch_done), 32'd0);
    check_eq("t5_ir", ir, Nop);
    check_eq("t5_ir_pc", ir_pc, 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);

`ifdef FETCH_MISALIGN_TRAP_EN
    @(negedge clock);
    fetch_req  = 1'b1;
    current_pc = 32'h0000_0102;
    @(negedge clock);
    fetch_req = 1'b0;
    check_eq("t6_valid", 32'(mem_req_valid), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_done", 32'(fetch_done), 32'd1);
    check_eq("t6_fault", 32'(fetch_fault), 32'd1);
    check_eq("t6_advance", 32'(pc_advance), 32'd0);
    check_eq("t6_ir", ir, ir_exp);
    check_eq("t6_ir_pc", ir_pc, 32'h0000_0102);
    irpc_exp = 32'h0000_0102;
    @(negedge clock);
    check_eq("t6_done_off", 32'(fetch_done), 32'd0);
    check_eq("t6_fault_off", 32'(fetch_fault), 32'd0);
`endif

    for (int n = 0; n < 60; n++) begin
      rdy = int'($urandom_range(0, 3));
      rsp = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) < 2) fl = -2;
      else fl = int'($urandom_range(0, rdy + rsp + 3)) - 1;
      pc = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      pc = pc & 32'hFFFF_FFFC;
`endif
      run_fetch($sformatf("rnd%0d", n), pc, $urandom, rdy, rsp, fl);
    end

    @(negedge clock);
    check_eq("final_done", 32'(fetch_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
